// File: rtl/msb_serial_pkg.sv
// Shared types and line levels for the MSB-first serial transmitter.
package msb_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register, MSB first, ones shifted in at the LSB.
module flex_pts_sr #(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] q;

  // Load wins over shift; the vacated LSB fills with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '1;
    end else if (load_enable) begin
      q <= parallel_in;
    end else if (shift_enable) begin
      q <= (q << 1) | NUM_BITS'(1);
    end
  end

  assign serial_out = q[NUM_BITS-1];

endmodule

// File: rtl/msb_serial_tx.sv
// Byte transmitter: start bit, NUM_BITS data bits MSB first, stop bit,
// each held CLKS_PER_BIT clocks, with a valid/ready input handshake.
module msb_serial_tx
  import msb_serial_pkg::*;
#(
  parameter int unsigned NUM_BITS     = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                serial_out,
  output logic                busy,
  output logic                tx_done
);

  localparam int unsigned CLK_CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BIT_CNT_W = $clog2(NUM_BITS + 1);
  localparam logic [CLK_CNT_W-1:0] CLK_LAST = CLK_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(NUM_BITS - 1);

  state_t               state;
  state_t               state_next;
  logic [CLK_CNT_W-1:0] clk_cnt;
  logic [CLK_CNT_W-1:0] clk_cnt_next;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt_next;
  logic                 serial_next;
  logic                 ready_next;
  logic                 busy_next;
  logic                 done_next;
  logic                 load_en;
  logic                 shift_en;
  logic                 sr_msb;
  logic                 accept;
  logic                 bit_end;

  assign accept  = tx_valid && tx_ready;
  assign bit_end = (clk_cnt == CLK_LAST);

  flex_pts_sr #(
    .NUM_BITS(NUM_BITS)
  ) u_sr (
    .clk         (clk),
    .rst         (rst),
    .load_enable (load_en),
    .shift_enable(shift_en),
    .parallel_in (tx_data),
    .serial_out  (sr_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      serial_out <= IDLE_LEVEL;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_next;
      clk_cnt    <= clk_cnt_next;
      bit_cnt    <= bit_cnt_next;
      serial_out <= serial_next;
      tx_ready   <= ready_next;
      busy       <= busy_next;
      tx_done    <= done_next;
    end
  end

  // The line value for the next bit is registered on the edge that starts it,
  // so each shift happens together with presenting the current MSB.
  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    serial_next  = serial_out;
    load_en      = 1'b0;
    shift_en     = 1'b0;

    case (state)
      IDLE: begin
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        serial_next  = IDLE_LEVEL;
        if (accept) begin
          state_next  = START;
          load_en     = 1'b1;
          serial_next = START_LEVEL;
        end
      end

      START: begin
        if (bit_end) begin
          state_next   = DATA;
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          serial_next  = sr_msb;
          shift_en     = 1'b1;
        end else begin
          clk_cnt_next = clk_cnt + CLK_CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          if (bit_cnt == BIT_LAST) begin
            state_next   = STOP;
            bit_cnt_next = '0;
            serial_next  = STOP_LEVEL;
          end else begin
            bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
            serial_next  = sr_msb;
            shift_en     = 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt + CLK_CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          if (accept) begin
            state_next  = START;
            load_en     = 1'b1;
            serial_next = START_LEVEL;
          end else begin
            state_next  = IDLE;
            serial_next = IDLE_LEVEL;
          end
        end else begin
          clk_cnt_next = clk_cnt + CLK_CNT_W'(1);
        end
      end

      default: begin
        state_next   = IDLE;
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        serial_next  = IDLE_LEVEL;
      end
    endcase

    // Handshake outputs describe the cycle that follows this edge.
    done_next  = (state_next == STOP) && (clk_cnt_next == CLK_LAST);
    ready_next = (state_next == IDLE) || done_next;
    busy_next  = (state_next != IDLE);
  end

endmodule

// File: tb/tb_msb_serial_tx.sv
// Self-checking bench for msb_serial_tx at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_msb_serial_tx;

  localparam int L4 = 40;
  localparam int L1 = 10;

  logic       clk;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, serial_out, busy, tx_done;
  logic [7:0] tx_data1 = 8'h00;
  logic       tx_valid1 = 1'b0;
  logic       tx_ready1, serial_out1, busy1, tx_done1;

  int total = 0;
  int bad = 0;

  msb_serial_tx #(.NUM_BITS(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .serial_out(serial_out), .busy(busy), .tx_done(tx_done)
  );

  msb_serial_tx #(.NUM_BITS(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .serial_out(serial_out1), .busy(busy1), .tx_done(tx_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level at cycle p after the accept edge.
  function automatic logic lvl(input logic [7:0] d, input int c, input int p);
    int idx;
    idx = p / c;
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return d[8-idx];
    else return 1'b1;
  endfunction

  // mode: 0 plain, 1 change tx_data right after accept, 2 pulse valid at cycle 10,
  //       3 hold valid with next byte for a back-to-back accept
  task automatic frame4(input logic [7:0] d, input int mode, input logic [7:0] alt,
                        input bit pre_accepted, input int abort_at);
    int n;
    n = 0;
    if (!pre_accepted) begin
      tx_data  = d;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && n < 100) begin
        @(posedge clk); #1; n++;
      end
      chk("ready_wait", 32'(tx_ready), 32'(1));
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    for (int p = 0; p < L4; p++) begin
      if (p == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_serial", 32'(serial_out), 32'(1));
        chk("abort_ready", 32'(tx_ready), 32'(1));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(tx_done), 32'(0));
        repeat (3) begin
          @(posedge clk); #1;
          chk("abort_hold_done", 32'(tx_done), 32'(0));
          chk("abort_hold_serial", 32'(serial_out), 32'(1));
        end
        rst = 1'b0;
        return;
      end
      chk("serial", 32'(serial_out), 32'(lvl(d, 4, p)));
      chk("ready", 32'(tx_ready), 32'(p == L4 - 1));
      chk("busy", 32'(busy), 32'(1));
      chk("done", 32'(tx_done), 32'(p == L4 - 1));
      if (mode == 1 && p == 0) tx_data = alt;
      if (mode == 2 && p == 10) begin tx_valid = 1'b1; tx_data = alt; end
      if (mode == 2 && p == 11) tx_valid = 1'b0;
      if (mode == 3 && p == 0) begin tx_valid = 1'b1; tx_data = alt; end
      @(posedge clk); #1;
    end
    if (mode != 3) begin
      chk("idle_serial", 32'(serial_out), 32'(1));
      chk("idle_ready", 32'(tx_ready), 32'(1));
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_done", 32'(tx_done), 32'(0));
    end
  endtask

  task automatic frame1(input logic [7:0] d);
    int n;
    n = 0;
    tx_data1  = d;
    tx_valid1 = 1'b1;
    while (tx_ready1 !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("c1_ready_wait", 32'(tx_ready1), 32'(1));
    @(posedge clk); #1;
    tx_valid1 = 1'b0;
    for (int p = 0; p < L1; p++) begin
      chk("c1_serial", 32'(serial_out1), 32'(lvl(d, 1, p)));
      chk("c1_ready", 32'(tx_ready1), 32'(p == L1 - 1));
      chk("c1_busy", 32'(busy1), 32'(1));
      chk("c1_done", 32'(tx_done1), 32'(p == L1 - 1));
      @(posedge clk); #1;
    end
    chk("c1_idle_serial", 32'(serial_out1), 32'(1));
    chk("c1_idle_busy", 32'(busy1), 32'(0));
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_serial", 32'(serial_out), 32'(1));
    chk("rst_ready", 32'(tx_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(tx_done), 32'(0));
    chk("rst_serial_c1", 32'(serial_out1), 32'(1));
    chk("rst_ready_c1", 32'(tx_ready1), 32'(1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_rst", 32'(serial_out), 32'(1));

    frame4(8'hA5, 0, 8'h00, 1'b0, -1);
    frame4(8'h00, 3, 8'hFF, 1'b0, -1);
    frame4(8'hFF, 0, 8'h00, 1'b1, -1);
    frame4(8'h81, 2, 8'h3C, 1'b0, -1);
    frame4(8'hF0, 1, 8'h0F, 1'b0, -1);
    frame4(8'h55, 0, 8'h00, 1'b0, 17);
    frame4(8'h55, 0, 8'h00, 1'b0, -1);
    for (int k = 0; k < 4; k++) begin
      frame4(8'($urandom), int'($urandom_range(0, 2)), 8'($urandom), 1'b0, -1);
    end

    frame1(8'h80);
    frame1(8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
